sysid_info_regs: RTL

- Parametrised successor to the single-word system-ID slave.
- Avalon-MM slave giving the host a fixed register map:
  - system ID, build timestamp and a capability word;
  - a writable scratch register;
  - a 64-bit free-running uptime counter with a coherent hi/lo snapshot and a control register;
  - N user-defined read-only words.
- Sits on the SOPC control bus beside the CPU; software uses it to identify the bitstream and to time events.

---
 rtl/sysid_pkg.sv | 32 +++
 rtl/sysid_uptime_counter.sv | 41 ++++
 rtl/sysid_info_regs.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - register map, CAPS layout and CONTROL bit indices for sysid_info_regs
package sysid_pkg;

    localparam int ADDR_SYSTEM_ID = 0;
    localparam int ADDR_TIMESTAMP = 1;
    localparam int ADDR_CAPS      = 2;
    localparam int ADDR_SCRATCH   = 3;
    localparam int ADDR_UPTIME_LO = 4;
    localparam int ADDR_UPTIME_HI = 5;
    localparam int ADDR_CONTROL   = 6;
    localparam int ADDR_RESERVED  = 7;
    localparam int ADDR_USER_BASE = 8;

    localparam int CAPS_VERSION_LSB = 16;
    localparam int CAPS_N_USER_LSB  = 8;
    localparam int CAPS_RD_LAT_LSB  = 0;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    // CAPS = {version[15:0], n_user[7:0], 6'b0, read_latency[1:0]}
    function automatic logic [31:0] caps_word(input logic [15:0] version,
                                              input int n_user,
                                              input int rd_lat);
        logic [31:0] w;
        w = (32'(version) << CAPS_VERSION_LSB)
          | (32'(n_user & 255) << CAPS_N_USER_LSB)
          | (32'(rd_lat & 3) << CAPS_RD_LAT_LSB);
        return w;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// rtl/sysid_uptime_counter.sv - prescaled 64-bit uptime counter with clear and freeze
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : one-cycle pulse, zeroes prescaler and count (wins over an increment)
//   freeze       : holds prescaler and count while high
//   count        : 64-bit uptime value
module sysid_uptime_counter
    import sysid_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    output logic [63:0] count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          wrap;

    // With TICK_DIV=1 the prescaler stays at 0 and every enabled cycle wraps.
    assign wrap = (prescaler == PW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prescaler <= '0;
            count     <= '0;
        end else if (!freeze) begin
            if (wrap) begin
                prescaler <= '0;
                count     <= count + 64'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sysid_info_regs.sv
// rtl/sysid_info_regs.sv - Avalon-MM system ID / build info / uptime register slave
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   address [ADDR_W]      : word address
//   read, write           : transfer strobes, accepted in the cycle asserted
//   writedata, byteenable : write data and byte lanes
//   readdata, readdatavalid : read response, READ_LATENCY cycles after accept
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter logic [15:0] VERSION       = 16'h0002,
    parameter int          N_USER        = 4,
    parameter logic [32*((N_USER > 0) ? N_USER : 1)-1:0] USER_WORDS = '0,
    parameter int          ADDR_W        = 5,
    parameter int          READ_LATENCY  = 1,
    parameter int          TICK_DIV      = 1,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [31:0] CAPS = caps_word(VERSION, N_USER, READ_LATENCY);

    logic [31:0] scratch;
    logic [31:0] shadow_hi;
    logic        freeze;
    logic [63:0] uptime;
    logic [31:0] addr_w;
    logic [31:0] rd_mux;
    logic        ctrl_wr;
    logic        clear_pulse;

    logic [31:0]             pipe_data  [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;

    assign addr_w      = 32'(address);
    assign ctrl_wr     = write && (addr_w == 32'(ADDR_CONTROL)) && byteenable[0];
    assign clear_pulse = ctrl_wr && writedata[CTRL_CLEAR_BIT];

    sysid_uptime_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_uptime (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_pulse),
        .freeze (freeze),
        .count  (uptime)
    );

    // Read mux sees register values before any same-cycle write lands.
    always_comb begin
        rd_mux = '0;
        case (addr_w)
            32'(ADDR_SYSTEM_ID): rd_mux = SYSTEM_ID;
            32'(ADDR_TIMESTAMP): rd_mux = TIMESTAMP;
            32'(ADDR_CAPS):      rd_mux = CAPS;
            32'(ADDR_SCRATCH):   rd_mux = scratch;
            32'(ADDR_UPTIME_LO): rd_mux = uptime[31:0];
            32'(ADDR_UPTIME_HI): rd_mux = shadow_hi;
            32'(ADDR_CONTROL):   rd_mux = {30'd0, freeze, 1'b0};
            32'(ADDR_RESERVED):  rd_mux = '0;
            default: begin
                for (int k = 0; k < N_USER; k++) begin
                    if (addr_w == 32'(ADDR_USER_BASE + k)) begin
                        rd_mux = USER_WORDS[32*k +: 32];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch   <= SCRATCH_RESET;
            shadow_hi <= '0;
            freeze    <= 1'b0;
        end else begin
            if (write && (addr_w == 32'(ADDR_SCRATCH))) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch[8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
            if (ctrl_wr) begin
                freeze <= writedata[CTRL_FREEZE_BIT];
            end
            // Latching the high word with the low-word read keeps a LO/HI pair coherent.
            if (read && (addr_w == 32'(ADDR_UPTIME_LO))) begin
                shadow_hi <= uptime[63:32];
            end
        end
    end

    // Data is zeroed in empty slots so readdata is 0 whenever readdatavalid is 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= read;
            pipe_data[0]  <= read ? rd_mux : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_valid[READ_LATENCY-1];

endmodule
